// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch stage with a DEPTH-entry decoupling FIFO
//                between a 1-cycle-latency instruction memory and decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned INC      = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               jorb,
    input  logic [PC_W-1:0]    newPC,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    PCPlus1
);

    localparam int unsigned     PTR_W  = $clog2(DEPTH);
    localparam int unsigned     CNT_W  = PTR_W + 1;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(INC);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic               deq;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     pending;

    assign instr_valid = (count != '0);
    assign deq         = instr_valid & instr_ready;
    assign push        = inflight & ~jorb;

    // Credits include the in-flight word; a same-cycle pop frees one slot.
    assign pending = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
    // Gated by rst so the strobe drops as soon as reset asserts.
    assign issue   = rst & ~jorb & ~halt & (pending < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign instr     = instr_mem[rd_ptr];
    assign PC        = pc_mem[rd_ptr];
    assign PCPlus1   = PC + PC_INC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= PC_RST;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (jorb) begin
            // Redirect: drop queued entries and the arriving response.
            fetch_pc <= newPC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            inflight    <= issue;
            inflight_pc <= fetch_pc;
            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed vector bench for fetch_queue with a 1-cycle memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic        jorb = 1'b0;
    logic [15:0] newPC = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] PC;
    logic [15:0] PCPlus1;

    int checks = 0;
    int errors = 0;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .jorb        (jorb),
        .newPC       (newPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .PC          (PC),
        .PCPlus1     (PCPlus1)
    );

    always #5 clk = ~clk;

    // Memory model: mem[a] = 16'hA000 | a, one cycle of latency.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (16'hA000 | imem_addr) : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        hlt;
        logic        jmp;
        logic [15:0] npc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rdy, logic hlt, logic jmp, logic [15:0] npc,
                                logic e_req, logic [15:0] e_addr,
                                logic e_valid, logic [15:0] e_pc, logic [15:0] e_instr);
        vec_t v;
        v.rdy = rdy; v.hlt = hlt; v.jmp = jmp; v.npc = npc;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic apply_and_check(input vec_t v, input int idx);
        instr_ready = v.rdy;
        halt        = v.hlt;
        jorb        = v.jmp;
        newPC       = v.npc;
        #1;
        check($sformatf("v%0d.req", idx),   {31'd0, imem_req},    {31'd0, v.e_req});
        check($sformatf("v%0d.addr", idx),  {16'd0, imem_addr},   {16'd0, v.e_addr});
        check($sformatf("v%0d.valid", idx), {31'd0, instr_valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            check($sformatf("v%0d.pc", idx),    {16'd0, PC},      {16'd0, v.e_pc});
            check($sformatf("v%0d.instr", idx), {16'd0, instr},   {16'd0, v.e_instr});
            check($sformatf("v%0d.pcp1", idx),  {16'd0, PCPlus1}, {16'd0, 16'(v.e_pc + 16'd1)});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Streaming, then backpressure from cycle 3
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000)); // 0
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000)); // 1
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0002, 1,16'h0000,16'hA000)); // 2
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h0003, 1,16'h0001,16'hA001)); // 3
        vecs.push_back(mk(0,0,0,16'h0000, 1,16'h0004, 1,16'h0001,16'hA001)); // 4
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0005, 1,16'h0001,16'hA001)); // 5 full
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0005, 1,16'h0001,16'hA001)); // 6
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0005, 1,16'h0001,16'hA001)); // 7 drain
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0006, 1,16'h0002,16'hA002)); // 8
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0007, 1,16'h0003,16'hA003)); // 9
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0008, 1,16'h0004,16'hA004)); // 10
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0009, 1,16'h0005,16'hA005)); // 11
        // Redirect with 3 queued + 1 in flight
        vecs.push_back(mk(1,0,1,16'h0040, 0,16'h000A, 1,16'h0006,16'hA006)); // 12
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0040, 0,16'h0000,16'h0000)); // 13
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0041, 0,16'h0000,16'h0000)); // 14
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0042, 1,16'h0040,16'hA040)); // 15
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0043, 1,16'h0041,16'hA041)); // 16
        // Halt for 5 cycles
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0044, 1,16'h0042,16'hA042)); // 17
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0044, 1,16'h0043,16'hA043)); // 18
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0044, 0,16'h0000,16'h0000)); // 19
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0044, 0,16'h0000,16'h0000)); // 20
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0044, 0,16'h0000,16'h0000)); // 21
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0044, 0,16'h0000,16'h0000)); // 22
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0045, 0,16'h0000,16'h0000)); // 23
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0046, 1,16'h0044,16'hA044)); // 24
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0047, 1,16'h0045,16'hA045)); // 25
        // Redirect to FFFE to exercise PC wrap
        vecs.push_back(mk(1,0,1,16'hFFFE, 0,16'h0048, 1,16'h0046,16'hA046)); // 26
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'hFFFE, 0,16'h0000,16'h0000)); // 27
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'hFFFF, 0,16'h0000,16'h0000)); // 28
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000, 1,16'hFFFE,16'hFFFE)); // 29
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0001, 1,16'hFFFF,16'hFFFF)); // 30
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0002, 1,16'h0000,16'hA000)); // 31
        // halt and jorb together: redirect taken, fetch waits for halt to drop
        vecs.push_back(mk(1,1,1,16'h0080, 0,16'h0003, 1,16'h0001,16'hA001)); // 32
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0080, 0,16'h0000,16'h0000)); // 33
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0080, 0,16'h0000,16'h0000)); // 34
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0081, 0,16'h0000,16'h0000)); // 35
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0082, 1,16'h0080,16'hA080)); // 36

        // Reset state
        #2;
        check("rst.valid", {31'd0, instr_valid}, 32'd0);
        check("rst.req",   {31'd0, imem_req},    32'd0);
        check("rst.instr", {16'd0, instr},       32'd0);
        check("rst.pc",    {16'd0, PC},          32'd0);
        check("rst.pcp1",  {16'd0, PCPlus1},     32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_and_check(vecs[i], i);
        end

        // Asynchronous reset mid-stream, not aligned to either edge
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst.valid", {31'd0, instr_valid}, 32'd0);
        check("arst.req",   {31'd0, imem_req},    32'd0);
        check("arst.pc",    {16'd0, PC},          32'd0);
        check("arst.pcp1",  {16'd0, PCPlus1},     32'd1);
        @(negedge clk);
        rst = 1'b1;
        apply_and_check(mk(1,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000), 100);
        apply_and_check(mk(1,0,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000), 101);
        apply_and_check(mk(1,0,0,16'h0000, 1,16'h0002, 1,16'h0000,16'hA000), 102);
        apply_and_check(mk(1,0,0,16'h0000, 1,16'h0003, 1,16'h0001,16'hA001), 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
